mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the MIPS core between two requesters: instruction fetch (I) and load/store data (D).
- Grants one requester at a time and drives the memory-side handshake.
- Returns read data and a one-cycle ack to the granted requester.
- D has priority, bounded by a fairness limit so fetch cannot starve; a watchdog terminates transactions whose memory never answers.

Parameters:
- MAX_DATA_BURST, 4, max consecutive D grants while I is pending (1..15).
- TIMEOUT, 16, cycles in BUSY without mem_ready before abort (2..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- i_req  in  1  fetch request, level, held until i_ack
- i_addr  in  32  fetch word address, stable while i_req
- i_ack  out  1  one-cycle pulse, fetch done
- i_rdata  out  32  fetch data, valid when i_ack
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1=store, 0=load
- d_be  in  4  byte enables for store
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse, data done
- d_rdata  out  32  load data, valid when d_ack
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- bus_err  out  1  one-cycle pulse coincident with the ack of an aborted transaction
- busy  out  1  1 while state=BUSY

Behaviour:
- All outputs are registered. On reset: state=IDLE and every output 0 (including rdata buses); streak counter=0, wait counter=0.
- States:
  - IDLE: no transaction in flight.
  - BUSY: mem_req=1; mem_we/mem_be/mem_addr/mem_wdata hold the values latched at grant.
- Arbitration happens in IDLE at the rising edge.
  - Eligible: i_req & ~i_ack for I; d_req & ~d_ack for D. The ack mask prevents re-granting a requester during its own ack cycle.
  - Both eligible, streak<MAX_DATA_BURST: grant D, streak+1.
  - Both eligible, streak==MAX_DATA_BURST: grant I, streak=0.
  - Only D eligible: grant D; streak unchanged.
  - Only I eligible: grant I, streak=0.
  - Neither eligible: stay in IDLE.
- Grant latches the owner and the memory fields and enters BUSY. mem_req rises in the cycle after the request is seen.
- An I grant always drives mem_we=0 and mem_be=4'b1111.
- Completion: in BUSY with mem_ready=1 at the edge:
  - the owner's ack goes to 1 for exactly one cycle;
  - the owner's rdata takes mem_rdata; a store also captures it, and the value is don't-care to the requester;
  - state returns to IDLE and mem_req drops;
  - the wait counter clears.
- Minimum transaction: req seen at edge N, mem_req high from N+1. If mem_ready is high in the first BUSY cycle, ack is high in cycle N+2. Back-to-back grants occur one cycle apart: the ack cycle is an IDLE cycle and can arbitrate the other requester.
- Watchdog: the wait counter increments each BUSY cycle without mem_ready. When it reaches TIMEOUT:
  - owner ack=1, bus_err=1, owner rdata=32'h0;
  - state returns to IDLE and the wait counter clears.
  - A mem_ready in that same cycle wins: normal completion, no bus_err.
- Non-owner acks stay 0. The non-owner rdata holds its last value.
- Requester dropping req while in BUSY: the transaction still completes and ack still pulses. The requester must tolerate this.
- Reset asserted mid-transaction: next edge forces IDLE and clears all outputs. No ack is issued for the aborted transaction.
- mem_ready while IDLE is ignored.

Test Plan:
- Reset hold, then release with no requests -> all outputs 0, busy=0 for 10 cycles.
- Single fetch: i_req=1, i_addr=0x00400000; memory returns 0x20080005 with 2-cycle latency -> mem_req high for 3 cycles with mem_addr=0x00400000, mem_we=0; i_ack pulses once; i_rdata=0x20080005; d_ack never asserts.
- Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x10010004, d_wdata=0xDEADBEEF, zero-wait memory -> mem_* fields match the request; d_ack pulses 2 cycles after the request.
- Fairness: I and D held continuously, MAX_DATA_BURST=4, zero-wait memory -> grant sequence D,D,D,D,I,D,D,D,D,I; no requester waits for more than 5 grants.
- Timeout: d_req load, memory never asserts mem_ready, TIMEOUT=16 -> 16 BUSY cycles, then d_ack=1, bus_err=1, d_rdata=0 in the same cycle; next cycle busy=0.
- Reset mid-transaction: reset=0 during the 2nd BUSY cycle -> next cycle mem_req=0 and busy=0; no i_ack/d_ack; a normal fetch after reset release completes correctly.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side bundle of the unified memory port arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        bus_err;
    logic        busy;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output bus_err, busy
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  bus_err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with data
// priority bounded by a fairness streak and a watchdog on unanswered requests.
module mem_port_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);
    localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_reg;
    logic        owner_d_reg;
    logic [3:0]  streak_reg;
    logic [7:0]  wait_reg;

    logic        i_ack_reg;
    logic [31:0] i_rdata_reg;
    logic        d_ack_reg;
    logic [31:0] d_rdata_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic        bus_err_reg;
    logic        busy_reg;

    logic        i_elig;
    logic        d_elig;
    logic        grant_d;
    logic        grant_i;

    // A requester still showing req during its own ack cycle is finishing, not asking again.
    assign i_elig  = bus.i_req & ~i_ack_reg;
    assign d_elig  = bus.d_req & ~d_ack_reg;
    assign grant_d = d_elig & (~i_elig | (streak_reg < BURST_LIMIT));
    assign grant_i = i_elig & ~grant_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_d_reg   <= 1'b0;
            streak_reg    <= 4'd0;
            wait_reg      <= 8'd0;
            i_ack_reg     <= 1'b0;
            i_rdata_reg   <= 32'd0;
            d_ack_reg     <= 1'b0;
            d_rdata_reg   <= 32'd0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 4'd0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            bus_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            i_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            bus_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        state_reg     <= BUSY;
                        owner_d_reg   <= 1'b1;
                        streak_reg    <= i_elig ? streak_reg + 4'd1 : streak_reg;
                        mem_req_reg   <= 1'b1;
                        busy_reg      <= 1'b1;
                        mem_we_reg    <= bus.d_we;
                        mem_be_reg    <= bus.d_be;
                        mem_addr_reg  <= bus.d_addr;
                        mem_wdata_reg <= bus.d_wdata;
                    end else if (grant_i) begin
                        state_reg     <= BUSY;
                        owner_d_reg   <= 1'b0;
                        streak_reg    <= 4'd0;
                        mem_req_reg   <= 1'b1;
                        busy_reg      <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_be_reg    <= 4'b1111;
                        mem_addr_reg  <= bus.i_addr;
                        mem_wdata_reg <= 32'd0;
                    end
                end
                BUSY: begin
                    // A ready arriving in the watchdog's final cycle still completes normally.
                    if (bus.mem_ready || (wait_reg == WAIT_LAST)) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        wait_reg    <= 8'd0;
                        bus_err_reg <= ~bus.mem_ready;
                        if (owner_d_reg) begin
                            d_ack_reg   <= 1'b1;
                            d_rdata_reg <= bus.mem_ready ? bus.mem_rdata : 32'd0;
                        end else begin
                            i_ack_reg   <= 1'b1;
                            i_rdata_reg <= bus.mem_ready ? bus.mem_rdata : 32'd0;
                        end
                    end else begin
                        wait_reg <= wait_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.i_ack     = i_ack_reg;
    assign bus.i_rdata   = i_rdata_reg;
    assign bus.d_ack     = d_ack_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_be    = mem_be_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.bus_err   = bus_err_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store, fairness, watchdog and
// mid-transaction reset, with a latency-programmable memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MAX_DATA_BURST(4),
        .TIMEOUT       (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          mem_lat;
    bit          mem_never;
    logic [31:0] mem_data;

    int          mreq_n, iack_n, dack_n, ack_at, field_bad, grant_n, busy_n;
    bit          got_ack, ack_any;
    logic [31:0] rdata_seen;
    byte         grant_seq [10];
    string       exp_seq = "DDDDIDDDDI";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Memory: asserts ready once mem_req has been high for mem_lat+1 cycles.
    initial begin
        int cnt;
        cnt           = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.mem_rdata = mem_data;
            if (bus.mem_req === 1'b1) begin
                cnt++;
                bus.mem_ready = !mem_never && (cnt > mem_lat);
            end else begin
                cnt           = 0;
                bus.mem_ready = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL tb_watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'd0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = 4'd0;
        bus.d_addr  = 32'd0;
        bus.d_wdata = 32'd0;
        mem_lat     = 0;
        mem_never   = 1'b0;
        mem_data    = 32'd0;

        // Reset hold and idle release
        repeat (3) tick();
        check_eq("rst_ctrl", {bus.mem_req, bus.mem_we, bus.mem_be, bus.i_ack, bus.d_ack, bus.bus_err, bus.busy}, 32'd0);
        check_eq("rst_addr", bus.mem_addr, 32'd0);
        check_eq("rst_wdata", bus.mem_wdata, 32'd0);
        check_eq("rst_irdata", bus.i_rdata, 32'd0);
        check_eq("rst_drdata", bus.d_rdata, 32'd0);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_eq($sformatf("idle_c%0d", c), {bus.busy, bus.mem_req, bus.i_ack, bus.d_ack, bus.bus_err}, 32'd0);
        end

        // Single fetch, 2-cycle memory latency
        mem_lat    = 2;
        mem_data   = 32'h2008_0005;
        bus.i_addr = 32'h0040_0000;
        bus.i_req  = 1'b1;
        mreq_n = 0; iack_n = 0; dack_n = 0; ack_at = 0; field_bad = 0; rdata_seen = 32'd0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.mem_req) begin
                mreq_n++;
                if (bus.mem_addr !== 32'h0040_0000 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'b1111)
                    field_bad++;
            end
            if (bus.i_ack) begin
                iack_n++;
                ack_at     = c;
                rdata_seen = bus.i_rdata;
                bus.i_req  = 1'b0;
            end
            if (bus.d_ack) dack_n++;
        end
        $display("txn fetch addr=%h rdata=%h ack_cycle=%0d", 32'h0040_0000, rdata_seen, ack_at);
        check_eq("fetch_mreq_cycles", mreq_n, 3);
        check_eq("fetch_mem_fields", field_bad, 0);
        check_eq("fetch_iack_count", iack_n, 1);
        check_eq("fetch_ack_cycle", ack_at, 4);
        check_eq("fetch_rdata", rdata_seen, 32'h2008_0005);
        check_eq("fetch_no_dack", dack_n, 0);

        // Store, zero-wait memory; d_req stays high through the ack cycle
        mem_lat     = 0;
        mem_data    = 32'h1234_5678;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'b0011;
        bus.d_addr  = 32'h1001_0004;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_req   = 1'b1;
        tick();
        check_eq("store_mreq", {bus.mem_req, bus.busy, bus.mem_we}, 32'b111);
        check_eq("store_be", bus.mem_be, 32'h3);
        check_eq("store_addr", bus.mem_addr, 32'h1001_0004);
        check_eq("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        $display("txn store addr=%h wdata=%h d_ack=%0b", 32'h1001_0004, 32'hDEAD_BEEF, bus.d_ack);
        check_eq("store_dack", {bus.d_ack, bus.i_ack, bus.mem_req}, 32'b100);
        check_eq("store_drdata", bus.d_rdata, 32'h1234_5678);
        tick();
        check_eq("store_no_regrant", {bus.d_ack, bus.busy, bus.mem_req}, 32'b000);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();

        // Fairness: both requesters pause only in ack cycles
        mem_data   = 32'hCAFE_F00D;
        bus.i_addr = 32'h0040_0004;
        bus.d_addr = 32'h1001_0008;
        bus.d_be   = 4'hF;
        grant_n    = 0;
        for (int g = 0; g < 10; g++) grant_seq[g] = 8'd0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int c = 0; c < 80 && grant_n < 10; c++) begin
            tick();
            ack_any = bus.i_ack | bus.d_ack;
            if (bus.i_ack && grant_n < 10) begin
                grant_seq[grant_n] = "I";
                grant_n++;
                $display("txn fair grant=%0d owner=I", grant_n);
            end
            if (bus.d_ack && grant_n < 10) begin
                grant_seq[grant_n] = "D";
                grant_n++;
                $display("txn fair grant=%0d owner=D", grant_n);
            end
            bus.i_req = !ack_any && (grant_n < 10);
            bus.d_req = !ack_any && (grant_n < 10);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check_eq("fair_count", grant_n, 10);
        for (int g = 0; g < 10; g++)
            check_eq($sformatf("fair_g%0d", g), 32'(grant_seq[g]), 32'(exp_seq[g]));
        repeat (2) tick();

        // Watchdog on a load that memory never answers
        mem_never  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h1001_0010;
        bus.d_req  = 1'b1;
        busy_n     = 0;
        got_ack    = 1'b0;
        for (int c = 0; c < 40 && !got_ack; c++) begin
            tick();
            if (bus.busy) busy_n++;
            if (bus.d_ack) begin
                got_ack = 1'b1;
                $display("txn timeout addr=%h bus_err=%0b d_rdata=%h", 32'h1001_0010, bus.bus_err, bus.d_rdata);
                check_eq("tmo_bus_err", bus.bus_err, 32'd1);
                check_eq("tmo_drdata", bus.d_rdata, 32'd0);
                check_eq("tmo_busy_at_ack", bus.busy, 32'd0);
                check_eq("tmo_irdata_hold", bus.i_rdata, 32'hCAFE_F00D);
                bus.d_req = 1'b0;
            end
        end
        check_eq("tmo_ack_seen", got_ack, 32'd1);
        check_eq("tmo_busy_cycles", busy_n, 16);
        tick();
        check_eq("tmo_after", {bus.d_ack, bus.bus_err, bus.busy}, 32'd0);
        mem_never = 1'b0;

        // Reset asserted in the second BUSY cycle of a fetch
        mem_lat    = 5;
        bus.i_addr = 32'h0040_0008;
        bus.i_req  = 1'b1;
        tick();
        check_eq("rstmid_busy1", bus.busy, 32'd1);
        tick();
        check_eq("rstmid_busy2", bus.busy, 32'd1);
        reset = 1'b0;
        tick();
        check_eq("rstmid_cleared", {bus.mem_req, bus.busy, bus.i_ack, bus.d_ack, bus.bus_err}, 32'd0);
        check_eq("rstmid_irdata", bus.i_rdata, 32'd0);
        reset    = 1'b1;
        mem_lat  = 1;
        mem_data = 32'h8C09_0000;
        iack_n = 0; ack_at = 0; field_bad = 0; rdata_seen = 32'd0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.mem_req && bus.mem_addr !== 32'h0040_0008) field_bad++;
            if (bus.i_ack) begin
                iack_n++;
                ack_at     = c;
                rdata_seen = bus.i_rdata;
                bus.i_req  = 1'b0;
            end
        end
        $display("txn fetch_after_reset addr=%h rdata=%h ack_cycle=%0d", 32'h0040_0008, rdata_seen, ack_at);
        check_eq("post_rst_addr", field_bad, 0);
        check_eq("post_rst_iack_count", iack_n, 1);
        check_eq("post_rst_ack_cycle", ack_at, 3);
        check_eq("post_rst_rdata", rdata_seen, 32'h8C09_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
